nclug_led_counter: RTL and testbench

//  Parametrised up/down LED counter, successor to the fixed 8-bit nclug2 counter. Adds clock prescaler,

---
 rtl/nclug_led_counter.sv | 105 ++++++++++
 tb/tb_nclug_led_counter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/nclug_led_counter.sv
// nclug_led_counter: parametrised up/down LED counter with clock prescaler,
// count enable, synchronous parallel load and wrap/saturate/bounce end modes.
// count drives the LED bank directly; tick/wrap are registered 1-cycle pulses.
module nclug_led_counter #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             gclk10,
    input  logic             btn_center_n,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap
);
    // Prescaler needs at least one bit even when PRESCALE = 1 (ps then stays 0).
    localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [1:0]       MODE_SAT = 2'b01;
    localparam logic [1:0]       MODE_BNC = 2'b10;

    logic            dir_m, dir_s;
    logic            rev;
    logic [PS_W-1:0] ps;
    logic            step;
    logic            bounce;
    logic            d;
    logic [WIDTH-1:0] count_nxt;
    logic            wrap_nxt;
    logic            rev_flip;

    assign step   = en && (ps == PS_LAST);
    assign bounce = (mode == MODE_BNC);
    // rev only ever becomes 1 in bounce mode, so d equals dir_s elsewhere.
    assign d      = dir_s ^ rev;

    // Next count value and end-of-range events, assuming a step happens.
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        rev_flip  = 1'b0;
        case (mode)
            MODE_SAT: begin
                if (dir_s) count_nxt = (count == ZERO) ? ZERO : count - ONE;
                else       count_nxt = (count == MAX)  ? MAX  : count + ONE;
            end
            MODE_BNC: begin
                if (!d && count == MAX) begin
                    count_nxt = MAX - ONE;
                    rev_flip  = 1'b1;
                    wrap_nxt  = 1'b1;
                end else if (d && count == ZERO) begin
                    count_nxt = ONE;
                    rev_flip  = 1'b1;
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = d ? count - ONE : count + ONE;
                end
            end
            default: begin
                // Wrap mode (00 and 11): natural modulo arithmetic.
                count_nxt = dir_s ? count - ONE : count + ONE;
                wrap_nxt  = dir_s ? (count == ZERO) : (count == MAX);
            end
        endcase
    end

    // State update: dir synchroniser, prescaler, count, bounce flag, pulses.
    always_ff @(posedge gclk10 or negedge btn_center_n) begin
        if (!btn_center_n) begin
            dir_m <= 1'b0;
            dir_s <= 1'b0;
            ps    <= '0;
            rev   <= 1'b0;
            count <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            dir_m <= dir;
            dir_s <= dir_m;
            if (load) begin
                // Load wins over any coincident step; the step is dropped.
                count <= load_val;
                ps    <= '0;
                rev   <= 1'b0;
                tick  <= 1'b0;
                wrap  <= 1'b0;
            end else begin
                tick <= step;
                wrap <= step && wrap_nxt;
                if (step) count <= count_nxt;
                if (en)   ps    <= step ? '0 : ps + 1'b1;
                // Leaving bounce mode clears the reversal so counting follows dir again.
                rev  <= bounce && (rev ^ (step && rev_flip));
            end
        end
    end

endmodule

// File: tb/tb_nclug_led_counter.sv
// Bench for nclug_led_counter: a 4-bit/prescale-4 instance and an
// 8-bit/prescale-1 instance share stimulus; both are checked every cycle
// against an arithmetic reference model.
module tb_nclug_led_counter;
    logic       gclk10 = 1'b0;
    logic       btn_center_n = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] lv4 = '0;
    logic [7:0] lv8 = '0;
    logic [3:0] c4;
    logic [7:0] c8;
    logic       t4, w4, t8, w8;
    int total = 0;
    int bad = 0;

    always #5 gclk10 = ~gclk10;

    nclug_led_counter #(.WIDTH(4), .PRESCALE(4)) dut4 (
        .gclk10(gclk10), .btn_center_n(btn_center_n), .en(en), .dir(dir),
        .mode(mode), .load(load), .load_val(lv4),
        .count(c4), .tick(t4), .wrap(w4));

    nclug_led_counter #(.WIDTH(8), .PRESCALE(1)) dut8 (
        .gclk10(gclk10), .btn_center_n(btn_center_n), .en(en), .dir(dir),
        .mode(mode), .load(load), .load_val(lv8),
        .count(c8), .tick(t8), .wrap(w8));

    // Reference state: count as an integer, prescale position, reversal flag,
    // last two dir samples (h1 is the one a step may use), expected pulses.
    typedef struct {
        int c;
        int ps;
        bit rev;
        bit h0;
        bit h1;
        bit tk;
        bit wr;
    } mdl_t;

    mdl_t m4, m8;

    function automatic mdl_t mreset();
        mdl_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int maxv, int pre, int lv);
        mdl_t n;
        bit ds, stp, d;
        n    = m;
        ds   = m.h1;
        n.tk = 0;
        n.wr = 0;
        n.h1 = m.h0;
        n.h0 = dir;
        if (load) begin
            n.c = lv;
            n.ps = 0;
            n.rev = 0;
            return n;
        end
        stp = en && (m.ps == pre - 1);
        if (en) n.ps = stp ? 0 : m.ps + 1;
        if (stp) begin
            n.tk = 1;
            if (mode == 2) begin
                d = ds ^ m.rev;
                if (!d && m.c == maxv) begin
                    n.c = maxv - 1; n.rev = !m.rev; n.wr = 1;
                end else if (d && m.c == 0) begin
                    n.c = 1; n.rev = !m.rev; n.wr = 1;
                end else begin
                    n.c = d ? m.c - 1 : m.c + 1;
                end
            end else if (mode == 1) begin
                n.c = ds ? ((m.c > 0) ? m.c - 1 : 0) : ((m.c < maxv) ? m.c + 1 : maxv);
            end else begin
                n.c = ds ? m.c - 1 : m.c + 1;
                if (n.c < 0 || n.c > maxv) begin
                    n.c = (n.c + maxv + 1) % (maxv + 1);
                    n.wr = 1;
                end
            end
        end
        if (mode != 2) n.rev = 0;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".c4"}, 32'(c4), 32'(m4.c));
        chk({tag, ".t4"}, 32'(t4), 32'(m4.tk));
        chk({tag, ".w4"}, 32'(w4), 32'(m4.wr));
        chk({tag, ".c8"}, 32'(c8), 32'(m8.c));
        chk({tag, ".t8"}, 32'(t8), 32'(m8.tk));
        chk({tag, ".w8"}, 32'(w8), 32'(m8.wr));
    endtask

    // One clock: advance the model with the inputs present at the edge, then check.
    task automatic cyc(input string tag);
        @(posedge gclk10);
        m4 = mstep(m4, 15, 4, int'(lv4));
        m8 = mstep(m8, 255, 1, int'(lv8));
        #1;
        check_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    initial begin
        m4 = mreset();
        m8 = mreset();
        #12;
        check_all("reset");
        #5 btn_center_n = 1'b1;

        // Free-running up count through 15->0 (and 255->0 later).
        en = 1'b1;
        run(70, "up_wrap");
        // Down count across 0->MAX.
        dir = 1'b1;
        run(40, "down_wrap");

        // Saturate at top, then at bottom.
        mode = 2'b01; dir = 1'b0; lv4 = 4'd14; lv8 = 8'd254; load = 1'b1;
        cyc("sat_load");
        load = 1'b0;
        run(20, "sat_up");
        lv4 = 4'd1; lv8 = 8'd1; load = 1'b1; dir = 1'b1;
        cyc("sat_load2");
        load = 1'b0;
        run(20, "sat_down");

        // Bounce at the top, then drop back to wrap mode.
        mode = 2'b10; dir = 1'b0; lv4 = 4'd13; lv8 = 8'd250; load = 1'b1;
        cyc("bnc_load");
        load = 1'b0;
        run(40, "bounce");
        dir = 1'b1;
        run(30, "bounce_dn");
        mode = 2'b00; dir = 1'b0;
        run(20, "bnc_to_wrap");

        // Load at every prescale phase, including the one coinciding with a step.
        for (int k = 0; k < 4; k++) begin
            lv4 = 4'(k + 5); lv8 = 8'(k + 100); load = 1'b1;
            cyc("load_phase");
            load = 1'b0;
            run(k + 3, "after_load");
        end
        en = 1'b0;
        run(10, "en_off");
        en = 1'b1;
        run(10, "en_on");

        // Asynchronous reset mid-cycle.
        run(2, "pre_rst");
        #2 btn_center_n = 1'b0;
        #1;
        m4 = mreset();
        m8 = mreset();
        check_all("async_rst");
        #1 btn_center_n = 1'b1;
        run(12, "post_rst");

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) dir = ~dir;
            if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
            load = ($urandom_range(0, 39) == 0);
            lv4 = 4'($urandom);
            lv8 = 8'($urandom);
            cyc("random");
        end

        // Long unloaded up run: 8-bit instance crosses 255->0.
        load = 1'b0; en = 1'b1; mode = 2'b00; dir = 1'b0;
        run(300, "long_up");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
